// File: rtl/flash_fill_ctrl.sv
// Flash-side fill engine: preloads the main SRAM window after reset, then fetches
// one SUB_DEPTH-word block per accepted read miss into the sub-SRAM.
module flash_fill_ctrl #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                SUB_DEPTH  = 64,
    parameter logic [ADDR_W-1:0] MAIN_LOWER = '0,
    parameter logic [ADDR_W-1:0] MAIN_UPPER = ADDR_W'(32'h400)
) (
    input  logic              clk,
    input  logic              grst,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ready,
    output logic              miss_err,
    output logic              boot_done,
    output logic              busy,
    output logic              flash_req,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic              flash_gnt,
    input  logic              flash_rvalid,
    input  logic [DATA_W-1:0] flash_rdata,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_main,
    output logic              wr_first,
    output logic              wr_last,
    input  logic              wr_ready,
    output logic              fill_done
);

    localparam int                CNT_W     = $clog2(SUB_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] BLK_MASK  = ADDR_W'(SUB_DEPTH - 1);
    localparam logic [ADDR_W-1:0] WIN_SIZE  = MAIN_UPPER - MAIN_LOWER;
    localparam logic [ADDR_W-1:0] MAIN_LAST = MAIN_UPPER - 1'b1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SUB_DEPTH - 1);

    typedef enum logic [2:0] {
        BOOT_REQ, BOOT_WAIT, BOOT_WR, IDLE, FILL_REQ, FILL_WAIT, FILL_WR
    } state_e;

    localparam state_e RST_STATE = (WIN_SIZE == '0) ? IDLE : BOOT_REQ;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              boot_done_q, boot_done_d;
    logic              miss_err_q, miss_err_d;
    logic              fill_done_q, fill_done_d;

    logic miss_acc;
    logic in_main;

    assign miss_acc = miss_valid & miss_ready;
    // Single unsigned compare covers both window bounds without a constant >= 0 test.
    assign in_main  = (miss_addr - MAIN_LOWER) < WIN_SIZE;

    always_ff @(posedge clk or negedge grst) begin
        if (!grst) begin
            state_q     <= RST_STATE;
            ptr_q       <= MAIN_LOWER;
            cnt_q       <= '0;
            hold_q      <= '0;
            boot_done_q <= 1'b0;
            miss_err_q  <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            boot_done_q <= boot_done_d;
            miss_err_q  <= miss_err_d;
            fill_done_q <= fill_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        boot_done_d = boot_done_q;
        miss_err_d  = 1'b0;
        fill_done_d = 1'b0;
        unique case (state_q)
            BOOT_REQ:  if (flash_gnt) state_d = BOOT_WAIT;
            FILL_REQ:  if (flash_gnt) state_d = FILL_WAIT;
            BOOT_WAIT: if (flash_rvalid) begin
                hold_d  = flash_rdata;
                state_d = BOOT_WR;
            end
            FILL_WAIT: if (flash_rvalid) begin
                hold_d  = flash_rdata;
                state_d = FILL_WR;
            end
            BOOT_WR: if (wr_ready) begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == MAIN_LAST) begin
                    boot_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = BOOT_REQ;
                end
            end
            IDLE: begin
                // Also covers an empty main window: done on the first cycle out of reset.
                boot_done_d = 1'b1;
                if (miss_acc) begin
                    if (in_main) begin
                        miss_err_d = 1'b1;
                    end else begin
                        ptr_d   = miss_addr & ~BLK_MASK;
                        cnt_d   = '0;
                        state_d = FILL_REQ;
                    end
                end
            end
            FILL_WR: if (wr_ready) begin
                ptr_d = ptr_q + 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    fill_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = FILL_REQ;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    // State decodes are gated by grst so every output drops the moment reset asserts.
    always_comb begin
        flash_req  = 1'b0;
        flash_addr = '0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_main    = 1'b0;
        wr_first   = 1'b0;
        wr_last    = 1'b0;
        busy       = 1'b0;
        miss_ready = 1'b0;
        if (grst) begin
            flash_req  = (state_q == BOOT_REQ) || (state_q == FILL_REQ);
            wr_valid   = (state_q == BOOT_WR) || (state_q == FILL_WR);
            wr_main    = (state_q == BOOT_WR);
            wr_first   = (state_q == FILL_WR) && (cnt_q == '0);
            wr_last    = ((state_q == BOOT_WR) && (ptr_q == MAIN_LAST)) ||
                         ((state_q == FILL_WR) && (cnt_q == CNT_LAST));
            busy       = (state_q != IDLE);
            miss_ready = (state_q == IDLE) && boot_done_q;
            if (flash_req) flash_addr = ptr_q;
            if (wr_valid) begin
                wr_addr = ptr_q;
                wr_data = hold_q;
            end
        end
    end

    assign boot_done = boot_done_q;
    assign miss_err  = miss_err_q;
    assign fill_done = fill_done_q;

endmodule
